// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and stereo pair type
package i2s_pkg;

    localparam int I2S_WIDTH_DEFAULT = 24;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Default-width pair; modules with a WIDTH parameter declare the same layout locally.
    typedef struct packed {
        logic [I2S_WIDTH_DEFAULT-1:0] left;
        logic [I2S_WIDTH_DEFAULT-1:0] right;
    } i2s_pair_t;

endpackage

// File: rtl/i2s_pair_fifo.sv
// rtl/i2s_pair_fifo.sv - two-entry stereo pair FIFO
module i2s_pair_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign full     = (count == 2'(DEPTH));
    assign empty    = (count == 2'd0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Storage is not reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_tx_slave.sv
// rtl/i2s_tx_slave.sv - I2S transmitter slaved to external sck/ws
module i2s_tx_slave
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic             sck,
    input  logic             reset_n,
    input  logic             ws,
    input  logic             en,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    output logic             s_ready,
    output logic             sd,
    output logic             frame_start,
    output logic             underrun
);

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    logic             ws_q;
    logic             ws_edge;
    logic             left_start;
    logic             right_start;
    logic             active;
    pair_t            hold;
    pair_t            head;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_word;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign ws_edge     = (ws != ws_q);
    assign left_start  = ws_edge && (ws == CH_LEFT);
    assign right_start = ws_edge && (ws == CH_RIGHT);
    assign s_ready     = reset_n && (fifo_count < 2'(DEPTH));
    assign push        = s_valid && reset_n && !fifo_full;
    assign pop         = en && left_start;

    i2s_pair_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (sck),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({s_left, s_right}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A right word is only sent once a left word of the same frame went out,
    // so enabling mid-frame never replays a stale hold register.
    always_comb begin
        load_word = '0;
        if (left_start) begin
            load_word = fifo_empty ? '0 : head.left;
        end else if (right_start && active) begin
            load_word = hold.right;
        end
    end

    always_ff @(posedge sck) begin
        if (!reset_n) begin
            ws_q        <= 1'b0;
            active      <= 1'b0;
            hold        <= '0;
            shreg       <= '0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            ws_q        <= ws;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (!en) begin
                active <= 1'b0;
                shreg  <= '0;
                sd     <= 1'b0;
            end else if (ws_edge) begin
                sd    <= load_word[WIDTH-1];
                shreg <= {load_word[WIDTH-2:0], 1'b0};
                if (left_start) begin
                    active      <= 1'b1;
                    frame_start <= 1'b1;
                    underrun    <= fifo_empty;
                    hold        <= fifo_empty ? '0 : head;
                end
            end else begin
                // Zeros shift in behind the LSB, giving the slot padding.
                sd    <= shreg[WIDTH-1];
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_slave.sv
// tb/tb_i2s_tx_slave.sv - randomized self-checking bench for i2s_tx_slave
module tb_i2s_tx_slave;

    localparam int WIDTH = 24;

    logic             sck = 1'b0;
    logic             reset_n = 1'b0;
    logic             ws = 1'b1;
    logic             en = 1'b1;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_left = '0;
    logic [WIDTH-1:0] s_right = '0;
    logic             s_ready;
    logic             sd;
    logic             frame_start;
    logic             underrun;

    always #5 sck = ~sck;

    i2s_tx_slave #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .sck         (sck),
        .reset_n     (reset_n),
        .ws          (ws),
        .en          (en),
        .s_valid     (s_valid),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_ready     (s_ready),
        .sd          (sd),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of pairs, current word and bit position since the last ws edge.
    logic [2*WIDTH-1:0] mq[$];
    logic [WIDTH-1:0]   m_hold_l = '0;
    logic [WIDTH-1:0]   m_hold_r = '0;
    logic [WIDTH-1:0]   m_word = '0;
    int                 m_idx = WIDTH;
    bit                 m_active = 0;
    logic               m_ws_prev = 1'b0;
    bit                 m_fs = 0;
    bit                 m_ur = 0;

    int                 slot = 32;
    int                 slot_left = 32;
    bit                 rand_slot = 0;
    logic [2*WIDTH-1:0] dir_q[$];
    int                 push_prob = 0;
    bit                 pending = 0;
    int                 en_flip = 0;

    logic [WIDTH-1:0]   cap = '0;
    int                 cap_n = WIDTH;
    bit                 cap_arm = 0;

    task automatic cycle();
        bit   exp_ready;
        bit   push;
        bit   ws_edge;
        logic exp_sd;
        slot_left--;
        if (slot_left <= 0) begin
            ws = ~ws;
            slot_left = rand_slot ? int'($urandom_range(2, 40)) : slot;
        end
        if (!pending) begin
            if (dir_q.size() > 0) begin
                {s_left, s_right} = dir_q.pop_front();
                pending = 1;
            end else if ($urandom_range(99) < push_prob) begin
                s_left  = WIDTH'($urandom);
                s_right = WIDTH'($urandom);
                pending = 1;
            end
        end
        s_valid = pending;
        if (en_flip > 0 && $urandom_range(999) < en_flip) en = ~en;
        #1;
        exp_ready = reset_n && (mq.size() < 2);
        check_val("s_ready", 32'(s_ready), 32'(exp_ready));
        push = s_valid && exp_ready;
        @(posedge sck);
        if (!reset_n) begin
            mq.delete();
            m_hold_l = '0; m_hold_r = '0; m_word = '0; m_idx = 0;
            m_active = 0; m_ws_prev = 1'b0; m_fs = 0; m_ur = 0;
        end else begin
            ws_edge = (ws != m_ws_prev);
            m_fs = 0;
            m_ur = 0;
            if (!en) begin
                m_active = 0; m_word = '0; m_idx = 0;
            end else if (ws_edge && ws == 1'b0) begin
                m_fs = 1;
                m_active = 1;
                if (mq.size() > 0) begin
                    {m_hold_l, m_hold_r} = mq.pop_front();
                end else begin
                    m_hold_l = '0; m_hold_r = '0; m_ur = 1;
                end
                m_word = m_hold_l;
                m_idx = 0;
            end else if (ws_edge) begin
                m_word = m_active ? m_hold_r : '0;
                m_idx = 0;
            end else if (m_idx < WIDTH) begin
                m_idx++;
            end
            m_ws_prev = ws;
            if (push) begin
                mq.push_back({s_left, s_right});
                pending = 0;
            end
        end
        #1;
        exp_sd = (m_idx < WIDTH) ? m_word[WIDTH-1-m_idx] : 1'b0;
        check_val("sd", 32'(sd), 32'(exp_sd));
        check_val("frame_start", 32'(frame_start), 32'(m_fs));
        check_val("underrun", 32'(underrun), 32'(m_ur));
        if (frame_start && cap_arm) begin
            cap_arm = 0;
            cap_n = 0;
        end
        if (cap_n < WIDTH) begin
            cap = {cap[WIDTH-2:0], sd};
            cap_n++;
        end
        @(negedge sck);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        @(negedge sck);
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;

        // Nominal frame with 32-cycle slots
        dir_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        cap_arm = 1;
        run(140);
        check_val("cap_done_a5", 32'(cap_n), 32'(WIDTH));
        check_val("left_a5", 32'(cap), 32'h00A5A5A5);

        // No data: every frame underruns
        run(130);

        // 16-cycle slots truncate the left word
        slot = 16;
        dir_q.push_back({24'h800001, 24'h123456});
        run(1);
        cap_arm = 1;
        run(80);
        check_val("cap_done_trunc", 32'(cap_n), 32'(WIDTH));
        check_val("left_trunc", 32'(cap), 32'h00800012);

        // Three back-to-back pairs
        slot = 32;
        dir_q.push_back({24'h111111, 24'h222222});
        dir_q.push_back({24'h333333, 24'h444444});
        dir_q.push_back({24'h555555, 24'h666666});
        run(220);

        // Reset mid-word flushes the buffer
        dir_q.push_back({24'h777777, 24'h888888});
        run(80);
        dir_q.push_back({24'h999999, 24'hAAAAAA});
        run(3);
        reset_n = 1'b0;
        run(1);
        reset_n = 1'b1;
        pending = 0;
        s_valid = 1'b0;
        run(150);

        // Disabled for two frames with one pair buffered
        en = 1'b0;
        dir_q.push_back({24'h3C0FF0, 24'h0F0F0F});
        run(130);
        en = 1'b1;
        cap_arm = 1;
        run(140);
        check_val("cap_done_en", 32'(cap_n), 32'(WIDTH));
        check_val("left_en", 32'(cap), 32'h003C0FF0);

        // Random slots, pushes, enables and occasional resets
        rand_slot = 1;
        push_prob = 30;
        en_flip = 5;
        for (int r = 0; r < 4; r++) begin
            run(500);
            reset_n = 1'b0;
            run(1);
            reset_n = 1'b1;
        end
        en_flip = 0;
        en = 1'b1;
        run(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
